// File: rtl/line_fill_engine.sv
// rtl/line_fill_engine.sv - scanline fill: background clear, then sprite overlay into the line buffer
// Optional horizontal sprite mirroring is compiled in with `define SPRITE_FLIP_EN.
module line_fill_engine #(
    parameter int          LINE_W      = 640,
    parameter int          NUM_SPRITES = 16,
    parameter int          SPR_W       = 16,
    parameter int          SPR_H       = 16,
    parameter logic [23:0] BG_COLOR    = 24'h5C94FC,
    parameter logic [23:0] TRANSPARENT = 24'hFF00FF
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [9:0]                     line_y,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(NUM_SPRITES)-1:0] spr_idx,
    input  logic                           spr_en,
    input  logic [9:0]                     spr_x,
    input  logic [9:0]                     spr_y,
    input  logic [5:0]                     spr_tile,
    input  logic                           spr_hflip,
    output logic [13:0]                    rom_addr,
    input  logic [23:0]                    rom_data,
    output logic                           lb_we,
    output logic [9:0]                     lb_addr,
    output logic [23:0]                    lb_data
);

    localparam int IW = $clog2(NUM_SPRITES);
    localparam int CB = $clog2(SPR_W);
    localparam int RB = $clog2(SPR_H);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_CHECK, S_DRAW, S_NEXT, S_FINISH
    } state_t;

    state_t          state, state_nxt;
    logic [9:0]      line_q;
    logic [9:0]      cnt;
    logic [IW-1:0]   spr_idx_q;
    logic [9:0]      x_q;
    logic [RB-1:0]   row_q;
    logic [5:0]      tile_q;

    logic            hit;
    logic [10:0]     y_end;
    logic            last_clear, last_draw, last_spr;
    logic [9:0]      px;
    logic [10:0]     pix_x;
    logic [CB-1:0]   col;
    logic            wr_ok;

    // Bounds are compared in 11 bits so a sprite near row/column 1023 never wraps to 0.
    assign y_end      = {1'b0, spr_y} + 11'(SPR_H);
    assign hit        = spr_en && ({1'b0, line_q} >= {1'b0, spr_y}) && ({1'b0, line_q} < y_end);
    assign last_clear = (cnt == 10'(LINE_W - 1));
    assign last_draw  = (cnt == 10'(SPR_W));
    assign last_spr   = (spr_idx_q == IW'(NUM_SPRITES - 1));

    // In DRAW, cnt issues the ROM read for column cnt while writing pixel cnt-1 from last cycle's read.
    assign px    = cnt - 10'd1;
    assign pix_x = {1'b0, x_q} + {1'b0, px};
    assign wr_ok = (cnt != 10'd0) && (rom_data != TRANSPARENT) && (pix_x < 11'(LINE_W));

`ifdef SPRITE_FLIP_EN
    logic flip_q;
    assign col = flip_q ? ~cnt[CB-1:0] : cnt[CB-1:0];
`else
    logic unused_hflip;
    assign unused_hflip = spr_hflip;
    assign col = cnt[CB-1:0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_CLEAR;
            S_CLEAR:  if (last_clear) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_CHECK;
            S_CHECK:  state_nxt = hit ? S_DRAW : S_NEXT;
            S_DRAW:   if (last_draw) state_nxt = S_NEXT;
            S_NEXT:   state_nxt = last_spr ? S_FINISH : S_FETCH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        lb_we    = 1'b0;
        lb_addr  = 10'd0;
        lb_data  = 24'd0;
        rom_addr = 14'd0;
        case (state)
            S_CLEAR: begin
                busy    = 1'b1;
                lb_we   = 1'b1;
                lb_addr = cnt;
                lb_data = BG_COLOR;
            end
            S_FETCH, S_CHECK, S_NEXT: busy = 1'b1;
            S_DRAW: begin
                busy     = 1'b1;
                rom_addr = 14'({tile_q, row_q, col});
                lb_we    = wr_ok;
                lb_addr  = pix_x[9:0];
                lb_data  = rom_data;
            end
            S_FINISH: done = 1'b1;
            default: ;
        endcase
    end

    assign spr_idx = spr_idx_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_q    <= 10'd0;
            cnt       <= 10'd0;
            spr_idx_q <= '0;
            x_q       <= 10'd0;
            row_q     <= '0;
            tile_q    <= 6'd0;
`ifdef SPRITE_FLIP_EN
            flip_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        line_q <= line_y;
                        cnt    <= 10'd0;
                    end
                end
                S_CLEAR: begin
                    if (last_clear) begin
                        cnt       <= 10'd0;
                        spr_idx_q <= '0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                S_CHECK: begin
                    if (hit) begin
                        x_q    <= spr_x;
                        row_q  <= RB'(line_q - spr_y);
                        tile_q <= spr_tile;
                        cnt    <= 10'd0;
`ifdef SPRITE_FLIP_EN
                        flip_q <= spr_hflip;
`endif
                    end
                end
                S_DRAW: cnt <= cnt + 10'd1;
                S_NEXT: if (!last_spr) spr_idx_q <= spr_idx_q + IW'(1);
                default: ;
            endcase
        end
    end

endmodule
